// File: rtl/seq_divider.sv
// Iterative restoring divider with built-in control: one quotient bit per cycle,
// unsigned or two's-complement operands, divide-by-zero flag and a one-cycle done pulse.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;
    logic             neg_n;
    logic             neg_d;

    logic             n_neg_in;
    logic             d_neg_in;
    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] rem_nx;

    // Two's-complement negate when requested; the most negative value maps onto
    // itself, which read as unsigned is exactly its magnitude.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        return neg ? WIDTH'(~v + 1'b1) : v;
    endfunction

    always_comb begin
        n_neg_in = signed_op & N[WIDTH-1];
        d_neg_in = signed_op & D[WIDTH-1];
        rem_sh   = {rem, dvd[WIDTH-1]};
        fits     = rem_sh >= {1'b0, dvs};
        rem_nx   = fits ? WIDTH'(rem_sh - {1'b0, dvs}) : rem_sh[WIDTH-1:0];
    end

    // The dividend register doubles as the quotient: each CALC cycle shifts one
    // dividend bit out of the top and one quotient bit into the bottom.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            neg_n       <= 1'b0;
            neg_d       <= 1'b0;
            Q           <= '0;
            R           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle itself never accepts a new request.
                    if (start && !done) begin
                        neg_n <= n_neg_in;
                        neg_d <= d_neg_in;
                        dvd   <= cond_neg(N, n_neg_in);
                        dvs   <= cond_neg(D, d_neg_in);
                        rem   <= '0;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        if (D == '0) begin
                            state       <= DONE;
                            Q           <= '1;
                            R           <= N;
                            div_by_zero <= 1'b1;
                        end else begin
                            state       <= CALC;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    dvd <= {dvd[WIDTH-2:0], fits};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    Q     <= cond_neg(dvd, neg_n ^ neg_d);
                    R     <= cond_neg(rem, neg_n);
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed and random bench for seq_divider: integer-arithmetic reference model,
// per-cycle compare of busy/done/results, plus hand-computed literal cases.
module tb_seq_divider;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic         signed_op;
    logic [W-1:0] N;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference state shared by driver and compare process
    logic         pending = 1'b0;
    int           t0      = 0;
    int           lat     = 0;
    logic [W-1:0] exp_q, exp_r, last_q, last_r;
    logic         exp_z, last_z;

    seq_divider #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .signed_op(signed_op),
        .N(N), .D(D), .Q(Q), .R(R), .busy(busy), .done(done),
        .div_by_zero(div_by_zero)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask

    // Division defined by plain integer arithmetic: SV '/' truncates toward zero
    // and '%' takes the sign of the dividend.
    function automatic void model(input logic [W-1:0] n, input logic [W-1:0] d, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        longint ni, di;
        if (d == '0) begin
            q = '1;
            r = n;
            z = 1'b1;
        end else begin
            if (s) begin
                ni = longint'($signed(n));
                di = longint'($signed(d));
            end else begin
                ni = longint'(n);
                di = longint'(d);
            end
            q = W'(ni / di);
            r = W'(ni % di);
            z = 1'b0;
        end
    endfunction

    always @(negedge CLK) begin : cmp
        int el;
        if (!RST) begin
            el = cyc - t0;
            if (pending) begin
                chk("busy", 32'(busy), 32'(el < lat));
                chk("done", 32'(done), 32'(el == lat));
                if (el >= lat) begin
                    chk("q", 32'(Q), 32'(exp_q));
                    chk("r", 32'(R), 32'(exp_r));
                    chk("dbz", 32'(div_by_zero), 32'(exp_z));
                    last_q  = exp_q;
                    last_r  = exp_r;
                    last_z  = exp_z;
                    pending = 1'b0;
                end
            end else begin
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_done", 32'(done), 32'd0);
                chk("hold_q", 32'(Q), 32'(last_q));
                chk("hold_r", 32'(R), 32'(last_r));
                chk("hold_dbz", 32'(div_by_zero), 32'(last_z));
            end
        end
    end

    task automatic start_op(input logic [W-1:0] n, input logic [W-1:0] d, input logic s);
        @(negedge CLK);
        N = n; D = d; signed_op = s; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        model(n, d, s, exp_q, exp_r, exp_z);
        lat     = exp_z ? 1 : W + 2;
        t0      = cyc;
        pending = 1'b1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4 * W && pending; i++) @(negedge CLK);
        if (pending) begin
            total++;
            $display("FAIL timeout: done not seen, expected within %0d cycles", lat);
            pending = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic [W-1:0] n, input logic [W-1:0] d);
        N = n; D = d; start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [W-1:0] n, input logic [W-1:0] d,
                       input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ez);
        logic [W-1:0] mq, mr;
        logic mz;
        start_op(n, d, s);
        wait_done();
        model(n, d, s, mq, mr, mz);
        chk({nm, "_model_q"}, 32'(mq), 32'(eq));
        chk({nm, "_model_r"}, 32'(mr), 32'(er));
        chk({nm, "_q"}, 32'(Q), 32'(eq));
        chk({nm, "_r"}, 32'(R), 32'(er));
        chk({nm, "_dbz"}, 32'(div_by_zero), 32'(ez));
    endtask

    initial begin
        RST = 1'b1; start = 1'b0; signed_op = 1'b0; N = '0; D = '0;
        last_q = '0; last_r = '0; last_z = 1'b0;
        exp_q = '0; exp_r = '0; exp_z = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_r", 32'(R), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        RST = 1'b0;

        lit("u100_7",    8'd100, 8'd7,    1'b0, 8'h0E, 8'h02, 1'b0);
        lit("s-100_7",   8'h9C,  8'd7,    1'b1, 8'hF2, 8'hFE, 1'b0);
        lit("s100_-7",   8'd100, 8'hF9,   1'b1, 8'hF2, 8'h02, 1'b0);
        lit("u_dbz",     8'h2A,  8'h00,   1'b0, 8'hFF, 8'h2A, 1'b1);
        lit("s_dbz",     8'h2A,  8'h00,   1'b1, 8'hFF, 8'h2A, 1'b1);
        lit("u9_3",      8'd9,   8'd3,    1'b0, 8'h03, 8'h00, 1'b0);
        lit("s_min_-1",  8'h80,  8'hFF,   1'b1, 8'h80, 8'h00, 1'b0);
        lit("uFF_1",     8'hFF,  8'h01,   1'b0, 8'hFF, 8'h00, 1'b0);
        lit("s-7_2",     8'hF9,  8'h02,   1'b1, 8'hFD, 8'hFF, 1'b0);
        lit("u5_200",    8'd5,   8'd200,  1'b0, 8'h00, 8'h05, 1'b0);

        // Restarts while computing must not disturb the running operation
        start_op(8'd200, 8'd9, 1'b0);
        repeat (3) @(negedge CLK);
        pulse_start(8'd1, 8'd1);
        repeat (4) @(negedge CLK);
        pulse_start(8'd1, 8'd1);
        wait_done();
        chk("ign_q", 32'(Q), 32'd22);
        chk("ign_r", 32'(R), 32'd2);

        // Abort mid-calculation
        start_op(8'd200, 8'd9, 1'b0);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        pending = 1'b0;
        last_q = '0; last_r = '0; last_z = 1'b0;
        #1;
        chk("abort_q", 32'(Q), 32'd0);
        chk("abort_r", 32'(R), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (12) @(negedge CLK);
        lit("after_rst", 8'd200, 8'd9, 1'b0, 8'd22, 8'd2, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] rn, rd;
            rn = W'($urandom);
            rd = W'($urandom);
            if (i % 17 == 0) rd = '0;
            if (i % 23 == 1) rn = 8'h80;
            if (i % 29 == 2) rd = 8'hFF;
            start_op(rn, rd, 1'(i % 2));
            wait_done();
        end

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Self-contained iterative integer divider with a built-in control FSM. It replaces the external-controller plus datapath split with a single block. It accepts a WIDTH-bit dividend and divisor on a start pulse and runs restoring long division, one quotient bit per cycle. It supports unsigned and signed (two's-complement) operation and divide-by-zero detection, and signals completion with a one-cycle done pulse. It sits between the operand source and the result consumer.

Parameters:
WIDTH, 8, operand/result width in bits (WIDTH >= 2)
CW, $clog2(WIDTH+1), iteration counter width (derived; not to be overridden)

Ports:
CLK  input  1  clock; all state changes on rising edge
RST  input  1  reset; asynchronous, active-high
start  input  1  request; sampled only in IDLE
signed_op  input  1  1 = two's-complement division, 0 = unsigned; sampled with start
N  input  WIDTH  dividend; sampled with start
D  input  WIDTH  divisor; sampled with start
Q  output  WIDTH  quotient; registered
R  output  WIDTH  remainder; registered
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
div_by_zero  output  1  registered flag for the last completed operation

Behaviour:
- Reset (async, RST=1):
  - State goes to IDLE.
  - Q=0, R=0, done=0, busy=0, div_by_zero=0.
  - Internal counter and operand registers are cleared.
  - RST asserted mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge e0:
  - Latch signed_op and the sign bits of N and D.
  - Latch |N| and |D|; magnitudes apply only when signed_op=1, raw values otherwise.
  - Clear the (WIDTH+1)-bit partial remainder and load counter=WIDTH.
  - If D==0: go to DONE; Q=all ones, R=N (raw), div_by_zero=1.
  - Otherwise: go to CALC, div_by_zero=0.
- CALC, one iteration per edge, WIDTH edges (e1..eWIDTH):
  - rem = {rem, dividend MSB}; shift the dividend left.
  - If rem >= divisor: rem -= divisor and the new quotient LSB = 1; else LSB = 0.
  - Decrement the counter. Exit to FIX on the edge where the counter reaches 0.
- FIX, one edge (eWIDTH+1):
  - If signed_op: negate the quotient when the sign of N differs from the sign of D; negate the remainder when N is negative.
  - Write Q and R. Go to DONE.
  - Magnitude of the most negative value is taken as an unsigned WIDTH-bit value. Most-negative / -1 therefore yields Q=most-negative, R=0, with no flag.
- DONE: done=1 for exactly this one cycle, then unconditionally go to IDLE. start seen in DONE is ignored.
- Latency: done is high in the cycle after edge e(WIDTH+2) for normal operation and after edge e1 for divide-by-zero. The next start is accepted in the cycle after done.
- start during CALC/FIX/DONE is ignored; operands are not re-sampled.
- Q, R and div_by_zero hold their values until the next operation writes them. A dbz result writes all three on entry to DONE.
- Signed results: the quotient truncates toward zero; the remainder takes the sign of the dividend.
- Invariant for non-dbz results: N == Q*D + R, in the selected signedness, modulo 2^WIDTH.

Test Plan:
- WIDTH=8, unsigned N=100, D=7, start at e0 -> busy high from e0; done pulse exactly 10 edges after e0; Q=14 (0x0E), R=2, div_by_zero=0.
- Signed N=0x9C (-100), D=7 -> Q=0xF2 (-14), R=0xFE (-2). Repeat with N=100, D=0xF9 (-7) -> Q=0xF2, R=0x02.
- N=0x2A, D=0 (unsigned and signed) -> done one edge after start; Q=0xFF, R=0x2A, div_by_zero=1. A following 9/3 operation -> Q=3, R=0, div_by_zero=0.
- Signed N=0x80, D=0xFF -> Q=0x80, R=0x00. Unsigned N=0xFF, D=0x01 -> Q=0xFF, R=0.
- Start 200/9; pulse start again with 1/1 at CALC iterations 3 and 7 -> ignored; result Q=22, R=2. Assert RST at iteration 4 -> Q=R=0, busy=0, no done pulse. New start after reset completes normally.
- Random sweep, WIDTH=8 and WIDTH=16, both modes, 10k vectors -> check the invariant above and exact done timing on every vector.
